// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard and flow controller for the in-order pipeline. It keeps a small
// tracker describing every instruction in stages 2..NSTAGE-1 and compares
// the sources of the instruction in operand fetch (stage 1) against it to
// find read-after-write hazards. It resolves each hazard in one of two ways:
// by forwarding from a later stage (FWD=1), or by stalling fetch and
// inserting a bubble into EX. A taken branch in EX flushes IF/OF and
// overrides any hazard. Two saturating counters record stall and flush
// cycles.
//
// Ports
//   clk                    rising-edge clock
//   reset                  asynchronous, active-low reset
//   id_valid               OF stage holds a real instruction
//   id_rs1 / id_rs2        OF source registers
//   id_rs1_use/id_rs2_use  OF source is actually read
//   id_wb / id_isld        OF instruction writes a register / is a load
//   id_rd                  OF destination register
//   ex_branch_taken        branch in stage 2 resolved taken this cycle
//   stall                  hold IF PC and the IF/OF register
//   bubble                 load a NOP into the OF/EX register
//   flush                  kill IF and OF contents
//   fwd_sel1 / fwd_sel2    0 = register file, k = forward from stage k
//   stall_cnt / flush_cnt  saturating event counters
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
   parameter int NSTAGE = 5,
   parameter int RA_W   = 4,
   parameter int FWD    = 1,
   parameter int CNT_W  = 16,
   parameter int SEL_W  = $clog2(NSTAGE)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [RA_W-1:0]  id_rs1,
   input  logic [RA_W-1:0]  id_rs2,
   input  logic             id_rs1_use,
   input  logic             id_rs2_use,
   input  logic             id_wb,
   input  logic             id_isld,
   input  logic [RA_W-1:0]  id_rd,
   input  logic             ex_branch_taken,
   output logic             stall,
   output logic             bubble,
   output logic             flush,
   output logic [SEL_W-1:0] fwd_sel1,
   output logic [SEL_W-1:0] fwd_sel2,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   // Tracker index i describes pipeline stage i+2.
   localparam int NTRK = NSTAGE - 2;

   logic [NTRK-1:0] trk_valid_r;
   logic [NTRK-1:0] trk_wb_r;
   logic [RA_W-1:0] trk_rd_r [NTRK];
   // The load flag only matters in stage 2 (load-use), so only that one is kept.
   logic            trk_isld_r;

   logic [CNT_W-1:0] stall_cnt_r;
   logic [CNT_W-1:0] flush_cnt_r;

   logic [NTRK-1:0]  m1_s;
   logic [NTRK-1:0]  m2_s;
   logic [SEL_W-1:0] stg1_s;
   logic [SEL_W-1:0] stg2_s;
   logic             haz1_s;
   logic             haz2_s;
   logic [SEL_W-1:0] sel1_s;
   logic [SEL_W-1:0] sel2_s;

   // Per-stage source matches and youngest matching stage for each operand.
   always_comb begin
      m1_s   = {NTRK{1'b0}};
      m2_s   = {NTRK{1'b0}};
      stg1_s = {SEL_W{1'b0}};
      stg2_s = {SEL_W{1'b0}};
      for (int i = 0; i < NTRK; i++) begin
         m1_s[i] = id_valid && id_rs1_use && trk_valid_r[i] && trk_wb_r[i] &&
                   (trk_rd_r[i] == id_rs1);
         m2_s[i] = id_valid && id_rs2_use && trk_valid_r[i] && trk_wb_r[i] &&
                   (trk_rd_r[i] == id_rs2);
      end
      // Walk oldest to youngest so the youngest match is left standing.
      for (int i = NTRK - 1; i >= 0; i--) begin
         stg1_s = m1_s[i] ? SEL_W'(i + 2) : stg1_s;
         stg2_s = m2_s[i] ? SEL_W'(i + 2) : stg2_s;
      end
   end

   // Hazard classification and raw forwarding selects per operand.
   always_comb begin
      haz1_s = 1'b0;
      haz2_s = 1'b0;
      sel1_s = {SEL_W{1'b0}};
      sel2_s = {SEL_W{1'b0}};
      if (FWD != 0) begin
         // Only a load still in EX cannot be forwarded.
         haz1_s = m1_s[0] && trk_isld_r;
         haz2_s = m2_s[0] && trk_isld_r;
         sel1_s = ((|m1_s) && !haz1_s) ? stg1_s : {SEL_W{1'b0}};
         sel2_s = ((|m2_s) && !haz2_s) ? stg2_s : {SEL_W{1'b0}};
      end else begin
         // No write-through register file: every match waits it out.
         haz1_s = |m1_s;
         haz2_s = |m2_s;
      end
   end

   // Flow-control outputs; reset forces quiet, a taken branch beats any hazard.
   always_comb begin
      stall    = 1'b0;
      bubble   = 1'b0;
      flush    = 1'b0;
      fwd_sel1 = {SEL_W{1'b0}};
      fwd_sel2 = {SEL_W{1'b0}};
      if (!reset) begin
         stall = 1'b0;
      end else if (ex_branch_taken) begin
         flush  = 1'b1;
         bubble = 1'b1;
      end else begin
         stall    = haz1_s || haz2_s;
         bubble   = haz1_s || haz2_s;
         fwd_sel1 = sel1_s;
         fwd_sel2 = sel2_s;
      end
   end

   // Tracker shift: stage 2 takes the OF instruction unless it is being killed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         trk_valid_r <= {NTRK{1'b0}};
         trk_wb_r    <= {NTRK{1'b0}};
         trk_isld_r  <= 1'b0;
         for (int i = 0; i < NTRK; i++) begin
            trk_rd_r[i] <= {RA_W{1'b0}};
         end
      end else begin
         trk_valid_r <= {trk_valid_r[NTRK-2:0], (id_valid && !(bubble || flush))};
         trk_wb_r    <= {trk_wb_r[NTRK-2:0], id_wb};
         trk_isld_r  <= id_isld;
         trk_rd_r[0] <= id_rd;
         for (int i = 1; i < NTRK; i++) begin
            trk_rd_r[i] <= trk_rd_r[i-1];
         end
      end
   end

   // Saturating stall / flush event counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_r <= {CNT_W{1'b0}};
         flush_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (stall && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
         if (flush && (flush_cnt_r != {CNT_W{1'b1}})) begin
            flush_cnt_r <= flush_cnt_r + CNT_W'(1);
         end else begin
            flush_cnt_r <= flush_cnt_r;
         end
      end
   end

   assign stall_cnt = stall_cnt_r;
   assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: three configurations share one stimulus
// stream (FWD=1/NSTAGE=5, FWD=0/NSTAGE=5, FWD=1/NSTAGE=6/CNT_W=4). A
// stage-list reference model checks every instance every cycle; a vector
// table and short directed sequences pin down the key scenarios.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       id_valid, id_rs1_use, id_rs2_use, id_wb, id_isld, br;
   logic [3:0] id_rs1, id_rs2, id_rd;

   logic        st_f, bb_f, fl_f, st_s, bb_s, fl_s, st_c, bb_c, fl_c;
   logic [2:0]  s1_f, s2_f, s1_s, s2_s, s1_c, s2_c;
   logic [15:0] sc_f, fc_f, sc_s, fc_s;
   logic [3:0]  sc_c, fc_c;

   pipeline_hazard_ctrl #(.NSTAGE(5), .RA_W(4), .FWD(1), .CNT_W(16)) u_f (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use), .id_wb(id_wb), .id_isld(id_isld),
      .id_rd(id_rd), .ex_branch_taken(br), .stall(st_f), .bubble(bb_f), .flush(fl_f),
      .fwd_sel1(s1_f), .fwd_sel2(s2_f), .stall_cnt(sc_f), .flush_cnt(fc_f));

   pipeline_hazard_ctrl #(.NSTAGE(5), .RA_W(4), .FWD(0), .CNT_W(16)) u_s (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use), .id_wb(id_wb), .id_isld(id_isld),
      .id_rd(id_rd), .ex_branch_taken(br), .stall(st_s), .bubble(bb_s), .flush(fl_s),
      .fwd_sel1(s1_s), .fwd_sel2(s2_s), .stall_cnt(sc_s), .flush_cnt(fc_s));

   pipeline_hazard_ctrl #(.NSTAGE(6), .RA_W(4), .FWD(1), .CNT_W(4)) u_c (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use), .id_wb(id_wb), .id_isld(id_isld),
      .id_rd(id_rd), .ex_branch_taken(br), .stall(st_c), .bubble(bb_c), .flush(fl_c),
      .fwd_sel1(s1_c), .fwd_sel2(s2_c), .stall_cnt(sc_c), .flush_cnt(fc_c));

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   // ---------------- reference model: list of in-flight instructions -----
   int ns_a[3]   = '{5, 5, 6};
   int fwd_a[3]  = '{1, 0, 1};
   int cmax_a[3] = '{65535, 65535, 15};
   bit mv[3][8];
   bit mwb[3][8];
   bit mld[3][8];
   int mrd[3][8];
   int msc[3];
   int mfc[3];
   bit est[3], ebb[3], efl[3];

   task automatic model_clear(input int k);
      for (int s = 0; s < 8; s++) begin
         mv[k][s] = 1'b0; mwb[k][s] = 1'b0; mld[k][s] = 1'b0; mrd[k][s] = 0;
      end
      msc[k] = 0;
      mfc[k] = 0;
   endtask

   // Nearest stage (from EX outward) writing register r, 0 if none.
   function automatic int youngest(input int k, input int r, input bit u);
      if (!(id_valid && u)) return 0;
      for (int s = 2; s < ns_a[k]; s++)
         if (mv[k][s] && mwb[k][s] && mrd[k][s] == r) return s;
      return 0;
   endfunction

   task automatic model_eval(input int k, output bit es, output bit eb, output bit ef,
                             output int e1, output int e2);
      int m1, m2;
      bit h1, h2;
      m1 = youngest(k, int'(id_rs1), id_rs1_use);
      m2 = youngest(k, int'(id_rs2), id_rs2_use);
      if (fwd_a[k] != 0) begin
         h1 = (m1 == 2) && mld[k][2];
         h2 = (m2 == 2) && mld[k][2];
      end else begin
         h1 = (m1 != 0);
         h2 = (m2 != 0);
      end
      e1 = (fwd_a[k] != 0 && !h1) ? m1 : 0;
      e2 = (fwd_a[k] != 0 && !h2) ? m2 : 0;
      es = h1 || h2;
      eb = es;
      ef = 1'b0;
      if (br) begin
         es = 1'b0; eb = 1'b1; ef = 1'b1; e1 = 0; e2 = 0;
      end
   endtask

   int obs_f_st, obs_f_bb, obs_f_fl, obs_f_s1, obs_f_s2, obs_f_sc, obs_f_fc;
   int obs_s_st, obs_s_s1, obs_s_sc, obs_c_st, obs_c_sc;

   // One clock: check at negedge, advance the model at posedge, release #1 after.
   task automatic cycle();
      bit es, eb, ef;
      int e1, e2;
      int a_st, a_bb, a_fl, a_s1, a_s2, a_sc, a_fc;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         if (!reset) model_clear(k);
         model_eval(k, es, eb, ef, e1, e2);
         if (!reset) begin
            es = 1'b0; eb = 1'b0; ef = 1'b0; e1 = 0; e2 = 0;
         end
         est[k] = es; ebb[k] = eb; efl[k] = ef;
         case (k)
            0: begin a_st = int'(st_f); a_bb = int'(bb_f); a_fl = int'(fl_f);
                     a_s1 = int'(s1_f); a_s2 = int'(s2_f); a_sc = int'(sc_f); a_fc = int'(fc_f); end
            1: begin a_st = int'(st_s); a_bb = int'(bb_s); a_fl = int'(fl_s);
                     a_s1 = int'(s1_s); a_s2 = int'(s2_s); a_sc = int'(sc_s); a_fc = int'(fc_s); end
            default: begin a_st = int'(st_c); a_bb = int'(bb_c); a_fl = int'(fl_c);
                     a_s1 = int'(s1_c); a_s2 = int'(s2_c); a_sc = int'(sc_c); a_fc = int'(fc_c); end
         endcase
         chk($sformatf("m%0d_stall", k),     a_st, int'(es));
         chk($sformatf("m%0d_bubble", k),    a_bb, int'(eb));
         chk($sformatf("m%0d_flush", k),     a_fl, int'(ef));
         chk($sformatf("m%0d_sel1", k),      a_s1, e1);
         chk($sformatf("m%0d_sel2", k),      a_s2, e2);
         chk($sformatf("m%0d_stall_cnt", k), a_sc, msc[k]);
         chk($sformatf("m%0d_flush_cnt", k), a_fc, mfc[k]);
      end
      obs_f_st = int'(st_f); obs_f_bb = int'(bb_f); obs_f_fl = int'(fl_f);
      obs_f_s1 = int'(s1_f); obs_f_s2 = int'(s2_f); obs_f_sc = int'(sc_f); obs_f_fc = int'(fc_f);
      obs_s_st = int'(st_s); obs_s_s1 = int'(s1_s); obs_s_sc = int'(sc_s);
      obs_c_st = int'(st_c); obs_c_sc = int'(sc_c);
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         if (!reset) begin
            model_clear(k);
         end else begin
            if (est[k] && msc[k] < cmax_a[k]) msc[k]++;
            if (efl[k] && mfc[k] < cmax_a[k]) mfc[k]++;
            for (int s = ns_a[k] - 1; s > 2; s--) begin
               mv[k][s] = mv[k][s-1]; mwb[k][s] = mwb[k][s-1];
               mld[k][s] = mld[k][s-1]; mrd[k][s] = mrd[k][s-1];
            end
            mv[k][2]  = id_valid && !(ebb[k] || efl[k]);
            mwb[k][2] = id_wb;
            mld[k][2] = id_isld;
            mrd[k][2] = int'(id_rd);
         end
      end
      #1;
   endtask

   task automatic rand_inputs();
      id_valid   = ($urandom_range(0, 3) != 0);
      id_rs1     = 4'($urandom_range(0, 5));
      id_rs2     = 4'($urandom_range(0, 5));
      id_rs1_use = 1'($urandom_range(0, 1));
      id_rs2_use = 1'($urandom_range(0, 1));
      id_wb      = ($urandom_range(0, 3) != 0);
      id_isld    = ($urandom_range(0, 2) == 0);
      id_rd      = 4'($urandom_range(0, 5));
      br         = ($urandom_range(0, 7) == 0);
   endtask

   task automatic set_in(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                         input bit wb, input bit ld, input int rd, input bit b);
      id_valid = v; id_rs1 = 4'(rs1); id_rs2 = 4'(rs2); id_rs1_use = u1; id_rs2_use = u2;
      id_wb = wb; id_isld = ld; id_rd = 4'(rd); br = b;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b0;
      for (int i = 0; i < n; i++) begin
         rand_inputs();
         cycle();
      end
      reset = 1'b1;
   endtask

   // ---------------- vector table for the FWD=1, NSTAGE=5 instance -------
   typedef struct {
      bit v; int rs1; int rs2; bit u1; bit u2; bit wb; bit ld; int rd; bit br;
      int est; int ebb; int efl; int es1; int es2; int esc; int efc;
   } vec_t;

   vec_t tbl[18];

   function automatic vec_t mk(bit v, int rs1, int rs2, bit u1, bit u2, bit wb, bit ld, int rd,
                               bit b, int st, int bb, int fl, int s1, int s2, int sc, int fc);
      vec_t r;
      r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2; r.wb = wb; r.ld = ld;
      r.rd = rd; r.br = b; r.est = st; r.ebb = bb; r.efl = fl; r.es1 = s1; r.es2 = s2;
      r.esc = sc; r.efc = fc;
      return r;
   endfunction

   initial begin
      int nst, nstl;
      bit done;
      int hold;

      for (int k = 0; k < 3; k++) model_clear(k);
      //              v rs1 rs2 u1 u2 wb ld rd br | st bb fl s1 s2 sc fc
      tbl[0]  = mk(1,  8,  9, 1, 1, 1, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(1, 10, 11, 1, 1, 1, 0, 3, 0,   0, 0, 0, 0, 0, 0, 0);
      tbl[2]  = mk(1,  3,  3, 1, 1, 1, 0, 4, 0,   0, 0, 0, 2, 2, 0, 0);
      tbl[3]  = mk(0,  3,  3, 1, 1, 1, 0, 9, 0,   0, 0, 0, 0, 0, 0, 0);
      tbl[4]  = mk(1,  4,  1, 1, 1, 1, 0, 5, 0,   0, 0, 0, 3, 0, 0, 0);
      tbl[5]  = mk(1,  4,  5, 1, 1, 1, 0, 6, 0,   0, 0, 0, 4, 2, 0, 0);
      tbl[6]  = mk(1,  6,  6, 0, 1, 1, 0, 7, 0,   0, 0, 0, 0, 2, 0, 0);
      tbl[7]  = mk(1,  6,  0, 1, 0, 1, 0, 6, 0,   0, 0, 0, 3, 0, 0, 0);
      tbl[8]  = mk(1,  6,  7, 1, 1, 1, 0, 8, 0,   0, 0, 0, 2, 3, 0, 0);
      tbl[9]  = mk(1,  8,  8, 1, 0, 0, 0, 8, 0,   0, 0, 0, 2, 0, 0, 0);
      tbl[10] = mk(1,  8,  9, 1, 1, 1, 0, 9, 0,   0, 0, 0, 3, 0, 0, 0);
      tbl[11] = mk(1,  1,  0, 1, 0, 1, 1, 5, 0,   0, 0, 0, 0, 0, 0, 0);
      tbl[12] = mk(1,  5,  1, 1, 1, 1, 0, 6, 0,   1, 1, 0, 0, 0, 0, 0);
      tbl[13] = mk(1,  5,  1, 1, 1, 1, 0, 6, 0,   0, 0, 0, 3, 0, 1, 0);
      tbl[14] = mk(1,  0,  0, 0, 0, 1, 1, 2, 0,   0, 0, 0, 0, 0, 1, 0);
      tbl[15] = mk(1,  2,  0, 1, 0, 1, 0, 3, 1,   0, 1, 1, 0, 0, 1, 0);
      tbl[16] = mk(1,  2,  6, 1, 1, 1, 0, 4, 0,   0, 0, 0, 3, 4, 1, 1);
      tbl[17] = mk(1,  3,  4, 1, 1, 0, 0, 0, 1,   0, 1, 1, 0, 0, 1, 1);

      // Reset held 3 cycles with random inputs: everything quiet.
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rand_inputs();
         cycle();
         chk("rst_stall", obs_f_st, 0);
         chk("rst_flush", obs_f_fl, 0);
         chk("rst_sel1",  obs_f_s1, 0);
         chk("rst_cnt",   obs_f_sc, 0);
      end
      reset = 1'b1;

      for (int i = 0; i < 18; i++) begin
         set_in(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].wb,
                tbl[i].ld, tbl[i].rd, tbl[i].br);
         cycle();
         chk($sformatf("tbl%0d_stall", i),  obs_f_st, tbl[i].est);
         chk($sformatf("tbl%0d_bubble", i), obs_f_bb, tbl[i].ebb);
         chk($sformatf("tbl%0d_flush", i),  obs_f_fl, tbl[i].efl);
         chk($sformatf("tbl%0d_sel1", i),   obs_f_s1, tbl[i].es1);
         chk($sformatf("tbl%0d_sel2", i),   obs_f_s2, tbl[i].es2);
         chk($sformatf("tbl%0d_scnt", i),   obs_f_sc, tbl[i].esc);
         chk($sformatf("tbl%0d_fcnt", i),   obs_f_fc, tbl[i].efc);
      end
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      chk("tbl_flush_cnt_end", obs_f_fc, 2);
      chk("tbl_stall_cnt_end", obs_f_sc, 1);

      // Stall-only mode: dependent pair at distance 1 stalls NSTAGE-2 cycles.
      do_reset(2);
      set_in(1, 0, 0, 0, 0, 1, 0, 2, 0);
      cycle();
      set_in(1, 2, 2, 1, 1, 1, 0, 7, 0);
      nst = 0;
      done = 1'b0;
      for (int n = 0; n < 10; n++) begin
         cycle();
         if (obs_s_st != 0) nst++;
         else begin
            done = 1'b1;
            break;
         end
      end
      chk("fwd0_released", int'(done), 1);
      chk("fwd0_stall_cycles", nst, 3);
      chk("fwd0_sel1", obs_s_s1, 0);
      chk("fwd0_stall_cnt", obs_s_sc, 3);

      // Saturation: back-to-back load-use on the 4-bit-counter instance.
      do_reset(2);
      set_in(1, 5, 0, 1, 0, 1, 1, 5, 0);
      nstl = 0;
      for (int n = 0; n < 44; n++) begin
         cycle();
         if (obs_c_st != 0) nstl++;
      end
      chk("sat_stall_events", int'(nstl >= 20), 1);
      chk("sat_cnt", obs_c_sc, 15);
      cycle();
      chk("sat_hold", obs_c_sc, 15);

      // Random traffic with occasional resets, including mid-stall/mid-flush.
      reset = 1'b1;
      hold = 0;
      for (int n = 0; n < 800; n++) begin
         if (hold > 0) begin
            hold--;
            reset = (hold == 0);
         end else if ($urandom_range(0, 79) == 0) begin
            hold = $urandom_range(1, 3);
            reset = 1'b0;
         end else begin
            reset = 1'b1;
         end
         rand_inputs();
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised hazard and flow controller for the in-order RISC pipeline. It tracks every instruction in flight beyond operand fetch and detects read-after-write hazards against the instruction in operand fetch. It drives stall, bubble and flush to the pipeline registers, plus per-operand forwarding selects for the execute stage. It generalises the fixed 5-stage datapath to NSTAGE stages, with a selectable forwarding or stall-only mode and saturating performance counters.

## Interface
- NSTAGE, 5: total stages. Stage 0 = IF, 1 = OF, 2 = EX (branch resolve), NSTAGE-1 = WB. Legal range 4..8.
- RA_W, 4: register address width (16 registers; r0 is an ordinary register).
- FWD, 1: 1 = forwarding mode, 0 = stall-only mode.
- CNT_W, 16: width of each performance counter.
- SEL_W, $clog2(NSTAGE): width of the forwarding selects.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  OF stage holds a real instruction.
- id_rs1, id_rs2  in  RA_W  source registers of the OF instruction.
- id_rs1_use, id_rs2_use  in  1  the corresponding source is actually read.
- id_wb, id_isld  in  1  OF instruction writes a register / is a load.
- id_rd  in  RA_W  OF destination register.
- ex_branch_taken  in  1  branch resolved taken in stage 2 this cycle.
- stall  out  1  hold the IF PC and the IF/OF pipeline register.
- bubble  out  1  load a NOP into the OF/EX register.
- flush  out  1  kill the IF and OF contents (wrong path).
- fwd_sel1, fwd_sel2  out  SEL_W  0 = register file; k = forward from stage k.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

## Operation
- Internal tracker holds entries for stages 2..NSTAGE-1. Each entry has {valid, wb, isld, rd}.
- Every cycle the tracker shifts by one stage. Stages at and beyond 2 never stall.
- Stage-2 entry load:
  - If bubble or flush is active, stage 2 is loaded with valid=0.
  - Otherwise stage 2 is loaded with {id_valid, id_wb, id_isld, id_rd}.
- Match for source s: id_valid & use_s & entry.valid & entry.wb & entry.rd==s. The youngest match (lowest stage index) wins.
- FWD=1:
  - No match: sel=0.
  - Match at stage 2 with isld=1: load-use hazard, so stall=1 and bubble=1.
  - Any other match at stage k: sel=k.
- FWD=0: any match causes stall=1 and bubble=1; sel always 0. The register file is not write-through, so a match in stage NSTAGE-1 also stalls.
- A selected source with no match uses sel=0.
- Branch:
  - ex_branch_taken=1 forces flush=1 and bubble=1.
  - It forces stall=0 and fwd_sel*=0, overriding any hazard.
  - The branching instruction itself continues down the pipeline.
- Counters:
  - stall_cnt increments on each cycle with stall=1.
  - flush_cnt increments on each cycle with flush=1.
  - Both hold at all-ones.

## Timing
- stall, bubble, flush and fwd_sel* are combinational from tracker state plus current inputs, valid in the same cycle. Tracker and counters are registered.
- Reset (asynchronous assert, synchronous release on next edge):
  - All tracker valids = 0 and counters = 0.
  - As a result stall = bubble = flush = 0 and fwd_sel* = 0 while reset is held.
- Reset asserted mid-stall or mid-flush drops all in-flight state immediately. No residual stall occurs after release.
- Dependent ALU pair at distance 1, FWD=1: 0 stall cycles, sel=2.
- Load-use pair, FWD=1: exactly 1 stall cycle, then sel=3.
- Dependent pair at distance 1, FWD=0: NSTAGE-2 stall cycles (3 for NSTAGE=5), then sel=0.
- Simultaneous hazard and ex_branch_taken: flush wins. No stall is counted; flush_cnt increments by 1.
- Both sources matching different stages resolve independently. stall is the OR of both operands' stall conditions.

## Test plan
- Reset: hold reset low 3 cycles with random inputs -> all outputs 0 and counters 0. Release -> first id_valid with no matches gives sel=0 and stall=0.
- FWD=1, NSTAGE=5: ADD r3 then SUB r4,r3,r3 back-to-back -> fwd_sel1=fwd_sel2=2, stall=0. Insert one NOP between them -> sel=3.
- FWD=1: LD r5 then ADD r6,r5,r1 -> stall=1 and bubble=1 for 1 cycle, then fwd_sel1=3. stall_cnt=1.
- FWD=0, NSTAGE=5: ADD r2 then ADD r7,r2,r2 -> stall for 3 cycles, then sel=0. stall_cnt=3.
- Branch: stall pending from a load-use case, with ex_branch_taken=1 in the same cycle -> flush=1, bubble=1, stall=0. Next cycle stage 2 is invalid; flush_cnt=1.
- Saturation: CNT_W=4, hold a continuous load-use pattern for 20 stalls -> stall_cnt reads 15 and stays at 15.
